// File: rtl/disp_sched.sv
// Display scheduler: picks which display-mux source (and which 16-bit half)
// drives the 7-segment display, either from switches or by timed auto-scan.
module disp_sched #(
    parameter int DWELL  = 16,
    parameter int BLANK  = 2,
    parameter int HALVES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_pause,
    input  logic        btn_half,
    input  logic [3:0]  manual_sel,
    input  logic [15:0] src_en,
    output logic [3:0]  sel,
    output logic        half,
    output logic        auto,
    output logic        blank,
    output logic        paused,
    output logic        advance
);

    localparam logic [15:0] DWELL_C  = 16'(DWELL);
    localparam logic [15:0] BLANK_C  = 16'(BLANK);
    localparam logic        HALVES_C = (HALVES != 0) ? 1'b1 : 1'b0;
    localparam logic        BLANK_EN = (BLANK != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_MANUAL   = 2'd0,
        ST_SHOW     = 2'd1,
        ST_BLANKING = 2'd2,
        ST_PAUSED   = 2'd3
    } state_t;

    // First enabled index at or after start, wrapping; start itself if none.
    function automatic logic [3:0] search_from(input logic [3:0] start, input logic [15:0] mask);
        logic [3:0] idx;
        logic [3:0] res;
        res = start;
        for (int i = 15; i >= 0; i--) begin
            idx = start + 4'(i);
            res = mask[idx] ? idx : res;
        end
        return res;
    endfunction

    function automatic logic [3:0] next_after(input logic [3:0] start, input logic [15:0] mask);
        return (mask == 16'd0) ? start : search_from(start + 4'd1, mask);
    endfunction

    state_t      state_r, state_nxt_s;
    logic [3:0]  sel_r, sel_nxt_s, step_sel_s;
    logic        half_r, half_nxt_s, step_half_s;
    logic        auto_r, blank_r, paused_r, advance_r;
    logic [15:0] dwell_cnt_r, dwell_nxt_s;
    logic [15:0] blank_cnt_r, blank_cnt_nxt_s;
    logic [3:0]  btn_q_r, btn_s, edge_s;
    logic        armed_r;
    logic        mode_e_s, next_e_s, pause_e_s, half_e_s;
    logic        dwell_done_s, blank_done_s, step_s;

    // armed_r masks the first cycle after reset so a button held through reset gives no edge
    assign btn_s     = {btn_half, btn_pause, btn_next, btn_mode};
    assign edge_s    = btn_s & ~btn_q_r & {4{armed_r}};
    assign mode_e_s  = edge_s[0];
    assign next_e_s  = edge_s[1];
    assign pause_e_s = edge_s[2];
    assign half_e_s  = edge_s[3];

    assign dwell_done_s = tick && ((dwell_cnt_r + 16'd1) == DWELL_C);
    assign blank_done_s = ((blank_cnt_r + 16'd1) == BLANK_C);
    assign step_s       = !mode_e_s && !pause_e_s &&
                          (((state_r == ST_SHOW) && (next_e_s || dwell_done_s)) ||
                           ((state_r == ST_PAUSED) && next_e_s));
    assign step_half_s  = HALVES_C && !half_r;
    assign step_sel_s   = step_half_s ? sel_r : next_after(sel_r, src_en);

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_MANUAL;
            sel_r       <= 4'd0;
            half_r      <= 1'b0;
            auto_r      <= 1'b0;
            blank_r     <= 1'b0;
            paused_r    <= 1'b0;
            advance_r   <= 1'b0;
            dwell_cnt_r <= 16'd0;
            blank_cnt_r <= 16'd0;
            btn_q_r     <= 4'd0;
            armed_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            sel_r       <= sel_nxt_s;
            half_r      <= half_nxt_s;
            auto_r      <= (state_nxt_s != ST_MANUAL);
            blank_r     <= (state_nxt_s == ST_BLANKING);
            paused_r    <= (state_nxt_s == ST_PAUSED);
            advance_r   <= step_s;
            dwell_cnt_r <= dwell_nxt_s;
            blank_cnt_r <= blank_cnt_nxt_s;
            btn_q_r     <= btn_s;
            armed_r     <= 1'b1;
        end
    end

    // Next-state decode, priority mode > pause > next > dwell/blank expiry
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_MANUAL: begin
                if (mode_e_s) state_nxt_s = ST_SHOW;
                else          state_nxt_s = ST_MANUAL;
            end
            ST_SHOW: begin
                if (mode_e_s)                state_nxt_s = ST_MANUAL;
                else if (pause_e_s)          state_nxt_s = ST_PAUSED;
                else if (step_s && BLANK_EN) state_nxt_s = ST_BLANKING;
                else                         state_nxt_s = ST_SHOW;
            end
            ST_BLANKING: begin
                if (mode_e_s)                   state_nxt_s = ST_MANUAL;
                else if (pause_e_s)             state_nxt_s = ST_PAUSED;
                else if (tick && blank_done_s)  state_nxt_s = ST_SHOW;
                else                            state_nxt_s = ST_BLANKING;
            end
            ST_PAUSED: begin
                if (mode_e_s)       state_nxt_s = ST_MANUAL;
                else if (pause_e_s) state_nxt_s = ST_SHOW;
                else                state_nxt_s = ST_PAUSED;
            end
            default: state_nxt_s = ST_MANUAL;
        endcase
    end

    // Datapath next values: select, half and the dwell/blank counters
    always_comb begin
        sel_nxt_s       = sel_r;
        half_nxt_s      = half_r;
        dwell_nxt_s     = dwell_cnt_r;
        blank_cnt_nxt_s = blank_cnt_r;
        case (state_r)
            ST_MANUAL: begin
                if (mode_e_s) begin
                    sel_nxt_s       = search_from(sel_r, src_en);
                    half_nxt_s      = 1'b0;
                    dwell_nxt_s     = 16'd0;
                    blank_cnt_nxt_s = 16'd0;
                end else begin
                    sel_nxt_s  = manual_sel;
                    half_nxt_s = half_e_s ? ~half_r : half_r;
                end
            end
            ST_SHOW: begin
                if (step_s) begin
                    sel_nxt_s       = step_sel_s;
                    half_nxt_s      = step_half_s;
                    dwell_nxt_s     = 16'd0;
                    blank_cnt_nxt_s = 16'd0;
                end else if (!mode_e_s && !pause_e_s && tick) begin
                    dwell_nxt_s = dwell_cnt_r + 16'd1;
                end else begin
                    dwell_nxt_s = dwell_cnt_r;
                end
            end
            ST_BLANKING: begin
                if (!mode_e_s && !pause_e_s && tick) begin
                    if (blank_done_s) begin
                        blank_cnt_nxt_s = 16'd0;
                        dwell_nxt_s     = 16'd0;
                    end else begin
                        blank_cnt_nxt_s = blank_cnt_r + 16'd1;
                    end
                end else begin
                    blank_cnt_nxt_s = blank_cnt_r;
                end
            end
            ST_PAUSED: begin
                if (step_s) begin
                    sel_nxt_s   = step_sel_s;
                    half_nxt_s  = step_half_s;
                    dwell_nxt_s = 16'd0;
                end else begin
                    dwell_nxt_s = dwell_cnt_r;
                end
            end
            default: begin
                sel_nxt_s  = sel_r;
                half_nxt_s = half_r;
            end
        endcase
    end

    assign sel     = sel_r;
    assign half    = half_r;
    assign auto    = auto_r;
    assign blank   = blank_r;
    assign paused  = paused_r;
    assign advance = advance_r;

endmodule

// File: tb/tb_disp_sched.sv
// Bench for disp_sched: directed vector table, reset corner cases, and a
// randomized run against a behavioural model of the scheduling rules.
module tb_disp_sched;

    localparam int P_DWELL  = 3;
    localparam int P_BLANK  = 2;
    localparam int P_HALVES = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick, btn_mode, btn_next, btn_pause, btn_half;
    logic [3:0]  manual_sel;
    logic [15:0] src_en;
    logic [3:0]  sel;
    logic        half, auto, blank, paused, advance;

    int checks = 0;
    int errors = 0;

    disp_sched #(.DWELL(P_DWELL), .BLANK(P_BLANK), .HALVES(P_HALVES)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_pause(btn_pause), .btn_half(btn_half),
        .manual_sel(manual_sel), .src_en(src_en),
        .sel(sel), .half(half), .auto(auto), .blank(blank), .paused(paused), .advance(advance)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode, nxt, pause, hlf, tck;
        logic [3:0]  msel;
        logic [15:0] mask;
        int          reps;
        logic [8:0]  exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic mode, nxt, pause, hlf, tck, input logic [3:0] msel,
                       input logic [15:0] mask, input int reps, input logic [3:0] esel,
                       input logic ehalf, eauto, eblank, epaused, eadv);
        vec_t v;
        v.mode = mode; v.nxt = nxt; v.pause = pause; v.hlf = hlf; v.tck = tck;
        v.msel = msel; v.mask = mask; v.reps = reps;
        v.exp  = {esel, ehalf, eauto, eblank, epaused, eadv};
        tbl.push_back(v);
    endtask

    function automatic logic [8:0] dut_out();
        return {sel, half, auto, blank, paused, advance};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got sel=%0d half=%b auto=%b blank=%b paused=%b advance=%b, expected sel=%0d half=%b auto=%b blank=%b paused=%b advance=%b",
                     name, got[8:5], got[4], got[3], got[2], got[1], got[0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic m, n, p, h);
        btn_mode = m; btn_next = n; btn_pause = p; btn_half = h;
    endtask

    // ---------------- behavioural reference model ----------------
    int m_sel, m_dwell, m_bc;
    bit m_half, m_auto, m_paused, m_blanking, m_adv, m_armed;
    bit p_mode, p_next, p_pause, p_half;

    function automatic int find_enabled(input int start, input logic [15:0] mask);
        int idx;
        for (int k = 0; k < 16; k++) begin
            idx = (start + k) % 16;
            if (mask[idx[3:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_sel = 0; m_dwell = 0; m_bc = 0;
        m_half = 0; m_auto = 0; m_paused = 0; m_blanking = 0; m_adv = 0; m_armed = 0;
        p_mode = 0; p_next = 0; p_pause = 0; p_half = 0;
    endtask

    task automatic do_step(input bit with_blank);
        m_dwell = 0;
        m_adv   = 1;
        if (P_HALVES == 1 && !m_half) m_half = 1;
        else begin
            m_half = 0;
            if (src_en != 16'd0) m_sel = find_enabled(m_sel + 1, src_en);
        end
        if (with_blank && P_BLANK > 0) begin
            m_blanking = 1;
            m_bc       = 0;
        end
    endtask

    task automatic model_step();
        bit em, en, ep, eh;
        int f;
        em = btn_mode  && !p_mode  && m_armed;
        en = btn_next  && !p_next  && m_armed;
        ep = btn_pause && !p_pause && m_armed;
        eh = btn_half  && !p_half  && m_armed;
        m_adv = 0;
        if (!m_auto) begin
            if (em) begin
                m_auto = 1;
                f = find_enabled(m_sel, src_en);
                if (f >= 0) m_sel = f;
                m_half = 0; m_dwell = 0; m_bc = 0;
            end else begin
                m_sel = int'(manual_sel);
                if (eh) m_half = !m_half;
            end
        end else if (em) begin
            m_auto = 0; m_paused = 0; m_blanking = 0;
        end else if (ep) begin
            if (m_paused) m_paused = 0;
            else begin
                m_paused = 1; m_blanking = 0;
            end
        end else if (m_paused) begin
            if (en) do_step(0);
        end else if (m_blanking) begin
            if (tick) begin
                m_bc++;
                if (m_bc == P_BLANK) begin
                    m_blanking = 0; m_bc = 0; m_dwell = 0;
                end
            end
        end else begin
            if (en) do_step(1);
            else if (tick) begin
                m_dwell++;
                if (m_dwell == P_DWELL) do_step(1);
            end
        end
        p_mode = btn_mode; p_next = btn_next; p_pause = btn_pause; p_half = btn_half;
        m_armed = 1;
    endtask

    function automatic logic [8:0] model_out();
        return {4'(m_sel), m_half, m_auto, m_blanking, m_paused, m_adv};
    endfunction

    initial begin
        // Buttons held high through reset must not toggle anything
        reset_n = 1'b0; tick = 1'b0; manual_sel = 4'd0; src_en = 16'h0012;
        set_btn(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) cyc();
        check("reset_state", dut_out(), 9'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("held_btn", dut_out(), 9'b0);
        end
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        check("btn_release", dut_out(), 9'b0);

        //   mode nxt pau hlf tck msel mask   reps | sel hlf aut blk pau adv
        add(0,0,0,0,0, 4'd5, 16'h0012, 1,  4'd5, 0,0,0,0,0);
        add(0,0,0,1,0, 4'd5, 16'h0012, 1,  4'd5, 1,0,0,0,0);
        add(0,0,0,0,0, 4'd0, 16'h0012, 1,  4'd0, 1,0,0,0,0);
        add(0,0,0,1,0, 4'd0, 16'h0012, 1,  4'd0, 0,0,0,0,0);
        add(0,0,0,0,0, 4'd0, 16'h0012, 1,  4'd0, 0,0,0,0,0);
        add(1,0,0,0,0, 4'd0, 16'h0012, 1,  4'd1, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 0,1,0,0,0);
        add(0,0,0,0,0, 4'd0, 16'h0012, 1,  4'd1, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 1,1,1,0,1);
        add(0,0,0,0,0, 4'd0, 16'h0012, 1,  4'd1, 1,1,1,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 1,1,1,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 1,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 2,  4'd1, 1,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd4, 0,1,1,0,1);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd4, 0,1,1,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd4, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 2,  4'd4, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd4, 1,1,1,0,1);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd4, 1,1,1,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd4, 1,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 2,  4'd4, 1,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 0,1,1,0,1);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 0,1,1,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 2,  4'd1, 0,1,0,0,0);
        add(0,0,1,0,0, 4'd0, 16'h0012, 1,  4'd1, 0,1,0,1,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 10, 4'd1, 0,1,0,1,0);
        add(0,0,1,0,0, 4'd0, 16'h0012, 1,  4'd1, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 1,1,1,0,1);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 1,1,1,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0012, 1,  4'd1, 1,1,0,0,0);
        add(0,0,1,0,0, 4'd0, 16'h0012, 1,  4'd1, 1,1,0,1,0);
        add(0,1,0,0,0, 4'd0, 16'h0012, 1,  4'd4, 0,1,0,1,1);
        add(0,0,0,0,0, 4'd0, 16'h0012, 1,  4'd4, 0,1,0,1,0);
        add(0,0,1,0,0, 4'd0, 16'h0012, 1,  4'd4, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0000, 2,  4'd4, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0000, 1,  4'd4, 1,1,1,0,1);
        add(0,0,0,0,1, 4'd0, 16'h0000, 1,  4'd4, 1,1,1,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0000, 1,  4'd4, 1,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0000, 2,  4'd4, 1,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0000, 1,  4'd4, 0,1,1,0,1);
        add(0,0,0,0,1, 4'd0, 16'h0000, 1,  4'd4, 0,1,1,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0000, 1,  4'd4, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0080, 2,  4'd4, 0,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0080, 1,  4'd4, 1,1,1,0,1);
        add(0,0,0,0,1, 4'd0, 16'h0080, 1,  4'd4, 1,1,1,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0080, 1,  4'd4, 1,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0080, 2,  4'd4, 1,1,0,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0080, 1,  4'd7, 0,1,1,0,1);
        add(0,0,0,0,1, 4'd0, 16'h0080, 1,  4'd7, 0,1,1,0,0);
        add(0,0,0,0,1, 4'd0, 16'h0080, 1,  4'd7, 0,1,0,0,0);
        add(1,1,0,0,0, 4'd0, 16'h0080, 1,  4'd7, 0,0,0,0,0);
        add(0,0,0,0,0, 4'd0, 16'h0080, 1,  4'd0, 0,0,0,0,0);

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                set_btn(tbl[i].mode, tbl[i].nxt, tbl[i].pause, tbl[i].hlf);
                tick = tbl[i].tck; manual_sel = tbl[i].msel; src_en = tbl[i].mask;
                cyc();
                check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
            end
        end

        // Asynchronous reset while blanking clears outputs without a clock edge
        set_btn(1'b1, 1'b0, 1'b0, 1'b0); tick = 1'b0;
        cyc();
        check("auto_entry_bit7", dut_out(), {4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        set_btn(1'b0, 1'b0, 1'b0, 1'b0); tick = 1'b1;
        repeat (3) cyc();
        check("blank_before_reset", dut_out(), {4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        tick = 1'b0;
        #3 reset_n = 1'b0;
        #1 check("async_reset", dut_out(), 9'b0);
        cyc();
        model_reset();
        reset_n = 1'b1;

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) btn_mode  = ~btn_mode;
            if ($urandom_range(0, 7)  == 0) btn_next  = ~btn_next;
            if ($urandom_range(0, 15) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(0, 7)  == 0) btn_half  = ~btn_half;
            tick       = ($urandom_range(0, 2) == 0);
            manual_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 2))
                    0:       src_en = 16'h0000;
                    1:       src_en = 16'($urandom);
                    default: src_en = 16'h0001 << $urandom_range(0, 15);
                endcase
            end
            model_step();
            cyc();
            check("random", dut_out(), model_out());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_sched.md
# disp_sched

Display scheduler for the board top level. It decides which of the 16 display-mux sources drives the 4-digit 7-segment display, and which 16-bit half of it. It replaces the direct switch-driven `display_select` with a manual/auto-scan state machine. Auto mode round-robins through an enable mask with a programmable dwell, blanks between sources, and accepts next/pause/mode requests from the sampled push buttons.

## Interface

Parameters:
- `DWELL`, 16, `tick` pulses each half (or whole source) is shown in auto mode; legal range 1..65535.
- `BLANK`, 2, `tick` pulses of blanking between displayed items; 0 disables blanking.
- `HALVES`, 1, 1 = auto mode shows low half then high half of each source; 0 = low half only.

Ports:
- `clk` in 1: system clock, single domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-`clk` enable strobe, the dwell time base (e.g. 100 Hz strobe).
- `btn_mode` in 1: level; a rising edge toggles manual/auto.
- `btn_next` in 1: level; a rising edge advances to the next item.
- `btn_pause` in 1: level; a rising edge toggles pause in auto mode.
- `btn_half` in 1: level; a rising edge toggles `half` in manual mode.
- `manual_sel` in 4: source index used in manual mode (switch field).
- `src_en` in 16: auto-scan enable mask, bit i = source i.
- `sel` out 4: registered display-mux select.
- `half` out 1: registered; 0 = data[15:0], 1 = data[31:16].
- `auto` out 1: 1 = auto mode active.
- `blank` out 1: 1 = display must be blanked.
- `paused` out 1: auto scan frozen.
- `advance` out 1: one-`clk` pulse each time `sel`/`half` changes in auto mode.

## Operation

- All button inputs are edge-detected inside the block. Each input has a 1-`clk` history register, and an edge is `btn & ~btn_q`. Synchronisation is upstream.
- States: MANUAL, SHOW, BLANKING, PAUSED.
- MANUAL:
  - `sel` = `manual_sel`, registered every clk.
  - `btn_half` edge toggles `half`.
  - `btn_mode` edge → SHOW with `sel` = first enabled index ≥ current `sel` (search wraps), `half`=0, dwell counter cleared.
- SHOW:
  - Dwell counter increments on each `tick`. When it reaches `DWELL` it clears and the block steps.
  - Step with `HALVES`=1 and `half`=0: set `half`=1 and stay on the same source.
  - Step otherwise: set `half`=0 and `sel` = next enabled index strictly after `sel`, modulo 16.
  - After a step the state is BLANKING if `BLANK`>0, otherwise it stays SHOW. `advance` pulses on the step cycle.
  - `btn_next` edge forces an immediate step and clears the dwell counter.
  - `btn_pause` edge → PAUSED.
  - `btn_mode` edge → MANUAL.
- BLANKING:
  - `blank`=1. Counts `BLANK` ticks, then → SHOW with the counter cleared.
  - `btn_mode` edge → MANUAL.
  - `btn_next` is ignored.
  - `btn_pause` edge → PAUSED, with blanking abandoned.
- PAUSED:
  - `paused`=1, `blank`=0. The counter holds its value.
  - `btn_pause` edge → SHOW, and the counter resumes from the held value.
  - `btn_next` edge steps once and stays PAUSED.
  - `btn_mode` edge → MANUAL.
- Empty mask (`src_en`=0):
  - A step keeps `sel` unchanged, but `half` still toggles per the rules.
  - The auto-entry search keeps the current `sel`.
  - No error state.
- Mask changes take effect at the next step or search. The current `sel` is never forced off mid-dwell.
- Event priority in one clk: `btn_mode` > `btn_pause` > `btn_next` > dwell expiry.
- `auto`=1 in SHOW, BLANKING and PAUSED. `blank`=1 only in BLANKING.

## Timing

- Reset values: state MANUAL, `sel`=0, `half`=0, `auto`=0, `blank`=0, `paused`=0, `advance`=0, counters 0, button history 0. A button held through reset produces no edge.
- All outputs are registered and change one clk after the causing edge or `tick`.
- Dwell: the step occurs on the clk after the `DWELL`-th `tick` counted in SHOW. The `tick` that causes entry into SHOW is not counted.
- Blanking lasts exactly `BLANK` tick periods measured in `tick` pulses.
- In MANUAL, `sel` tracks `manual_sel` with one clk latency.
- `reset_n` asserted mid-operation clears everything immediately (asynchronous). Deassertion is synchronised upstream.

## Test plan

- Reset with all buttons high, then release reset → `sel`=0, `auto`=0, `blank`=0. No toggle occurs until a button falls and rises again.
- MANUAL, `manual_sel`=5 → `sel`=5 one clk later. `btn_half` edge → `half`=1.
- `DWELL`=3, `BLANK`=2, `HALVES`=1, `src_en`=16'h0012, mode edge from `sel`=0:
  - Expected sequence: `sel`=1/`half`=0 for 3 ticks, blank 2 ticks, `sel`=1/`half`=1, blank, `sel`=4/`half`=0, then wrap to `sel`=1.
  - `advance` pulses exactly once per step.
- Auto mode, pause at dwell count 2 → 10 ticks produce no change. Resume → step after 1 more tick. `btn_next` while paused → one step and still `paused`=1.
- `src_en`=0 in auto with `HALVES`=1 → `sel` constant, `half` alternates every `DWELL` ticks. Setting bit 7 → the next full step gives `sel`=7.
- Same-clk `btn_mode` and `btn_next` edges in SHOW → MANUAL, no step, `advance`=0. Asserting `reset_n`=0 while in BLANKING → all outputs 0 immediately.
